// File: rtl/inst_fetch_pkg.sv
// Shared core definitions for the RV32I fetch stage: data widths, reset vector,
// the canonical NOP encoding and the {pc, inst} pair carried through the fetch buffer.
package inst_fetch_pkg;

   localparam int unsigned XLEN        = 32;
   localparam int unsigned FETCH_DEPTH = 4;

   localparam logic [XLEN-1:0] RESET_VEC = 32'h0000_0000;
   // addi x0, x0, 0
   localparam logic [XLEN-1:0] NOP_INST  = 32'h0000_0013;

   // One fetched instruction paired with its address
   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] inst;
   } fetch_pair_t;

endpackage

// File: rtl/inst_fetch_if.sv
// Fetch-stage bus: PC-side request inputs, instruction-memory read port and the
// decode-side {PC, instruction} output.
//   master : the fetch stage (drives memory request, F_BUSY and F_* outputs)
//   slave  : the environment (PC generator, instruction memory, decode)
interface inst_fetch_if;
   import inst_fetch_pkg::*;

   logic [XLEN-1:0] P_PC;
   logic            P_VALID;
   logic            INST_RDEN;
   logic [XLEN-1:0] INST_RDADDR;
   logic            INST_RDVALID;
   logic [XLEN-1:0] INST_RDDATA;
   logic            F_BUSY;
   logic [XLEN-1:0] F_PC;
   logic [XLEN-1:0] F_INST;
   logic            F_VALID;

   modport master (
      input  P_PC, P_VALID, INST_RDVALID, INST_RDDATA,
      output INST_RDEN, INST_RDADDR, F_BUSY, F_PC, F_INST, F_VALID
   );

   modport slave (
      output P_PC, P_VALID, INST_RDVALID, INST_RDDATA,
      input  INST_RDEN, INST_RDADDR, F_BUSY, F_PC, F_INST, F_VALID
   );

endinterface

// File: rtl/inst_fetch_buf.sv
// In-order fetch buffer: entries are allocated at issue, filled by memory
// responses in request order and popped at the head.
//   clk_i, rst_i     : clock, synchronous active-high reset
//   clear_i          : drop all entries (redirect)
//   alloc_i/pc       : allocate an entry at the tail with the issued PC
//   fill_i/inst      : write the oldest unfilled entry
//   pop_i            : retire the head entry
//   head_o           : head {pc, inst};  head_filled_o : head holds its instruction
//   count_o          : allocated, not yet popped entries
//   unfilled_o       : allocated entries still waiting for their response
module inst_fetch_buf
   import inst_fetch_pkg::*;
#(
   parameter int unsigned DEPTH = FETCH_DEPTH
) (
   input  logic                             clk_i,
   input  logic                             rst_i,
   input  logic                             clear_i,
   input  logic                             alloc_i,
   input  logic [XLEN-1:0]                  alloc_pc_i,
   input  logic                             fill_i,
   input  logic [XLEN-1:0]                  fill_inst_i,
   input  logic                             pop_i,
   output fetch_pair_t                      head_o,
   output logic                             head_filled_o,
   output logic [$clog2(DEPTH):0]           count_o,
   output logic [$clog2(DEPTH):0]           unfilled_o
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned PW = AW + 1;

   fetch_pair_t   buf_q [DEPTH];
   logic [PW-1:0] wr_q, wr_d;
   logic [PW-1:0] fill_q, fill_d;
   logic [PW-1:0] rd_q, rd_d;

   // Pointer advance; extra MSB distinguishes full from empty
   always_comb begin
      wr_d   = wr_q;
      fill_d = fill_q;
      rd_d   = rd_q;
      if (clear_i) begin
         wr_d   = '0;
         fill_d = '0;
         rd_d   = '0;
      end else begin
         if (alloc_i) wr_d   = wr_q   + PW'(1);
         if (fill_i)  fill_d = fill_q + PW'(1);
         if (pop_i)   rd_d   = rd_q   + PW'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_q   <= '0;
         fill_q <= '0;
         rd_q   <= '0;
      end else begin
         wr_q   <= wr_d;
         fill_q <= fill_d;
         rd_q   <= rd_d;
      end
   end

   // Entry storage; an unfilled slot carries a NOP until its response lands.
   // Alloc and fill never target the same slot: that would need a full buffer.
   always_ff @(posedge clk_i) begin
      if (alloc_i && !clear_i) begin
         buf_q[wr_q[AW-1:0]] <= '{pc: alloc_pc_i, inst: NOP_INST};
      end
      if (fill_i && !clear_i) begin
         buf_q[fill_q[AW-1:0]].inst <= fill_inst_i;
      end
   end

   // Entries between rd and fill are filled, so the head is filled whenever
   // the fill pointer has moved past it.
   assign head_o        = buf_q[rd_q[AW-1:0]];
   assign head_filled_o = (fill_q != rd_q);
   assign count_o       = wr_q - rd_q;
   assign unfilled_o    = wr_q - fill_q;

endmodule

// File: rtl/inst_fetch.sv
// RV32I fetch stage: issues in-order instruction reads for incoming PCs, pairs
// each response with its PC in a small buffer and presents one {PC, inst} per
// cycle to decode. Handles stall and flush, discarding responses that were in
// flight when a flush hit.
//   CLK, RST   : clock, synchronous active-high reset
//   STALL      : hold F_* outputs and block issue
//   FLUSH      : redirect; empty the buffer and drop in-flight responses
//   fetch_bus  : PC request, instruction memory port, F_BUSY and decode outputs
module inst_fetch
   import inst_fetch_pkg::*;
#(
   parameter int unsigned DEPTH = FETCH_DEPTH
) (
   input  logic          CLK,
   input  logic          RST,
   input  logic          STALL,
   input  logic          FLUSH,
   inst_fetch_if.master  fetch_bus
);

   localparam int unsigned PW = $clog2(DEPTH) + 1;
   localparam int unsigned SW = PW + 1;

   fetch_pair_t     head;
   logic            head_filled;
   logic [PW-1:0]   count;
   logic [PW-1:0]   unfilled;

   logic [PW-1:0]   drop_q, drop_d;
   logic            f_valid_q, f_valid_d;
   logic [XLEN-1:0] f_pc_q, f_pc_d;
   logic [XLEN-1:0] f_inst_q, f_inst_d;

   logic [SW-1:0]   credit_used;
   logic [SW-1:0]   drop_sum;
   logic            busy;
   logic            issue;
   logic            rsp;
   logic            drop_rsp;
   logic            fill;
   logic            pop;

   // Credits cover buffered entries plus responses still owed from before a
   // flush, so a read is only issued when its response has a home.
   assign credit_used = SW'(count) + SW'(drop_q);
   assign busy        = (credit_used >= SW'(DEPTH));
   assign issue       = fetch_bus.P_VALID && !STALL && !FLUSH && !RST && !busy;

   assign rsp      = fetch_bus.INST_RDVALID;
   assign drop_rsp = rsp && (drop_q != '0);
   assign fill     = rsp && !FLUSH && !RST && (drop_q == '0) && (unfilled != '0);
   assign pop      = !RST && !FLUSH && !STALL && head_filled;

   inst_fetch_buf #(
      .DEPTH (DEPTH)
   ) u_buf (
      .clk_i         (CLK),
      .rst_i         (RST),
      .clear_i       (FLUSH),
      .alloc_i       (issue),
      .alloc_pc_i    (fetch_bus.P_PC),
      .fill_i        (fill),
      .fill_inst_i   (fetch_bus.INST_RDDATA),
      .pop_i         (pop),
      .head_o        (head),
      .head_filled_o (head_filled),
      .count_o       (count),
      .unfilled_o    (unfilled)
   );

   // Drop counter and decode output register next state
   always_comb begin
      drop_d    = drop_q;
      drop_sum  = '0;
      f_valid_d = f_valid_q;
      f_pc_d    = f_pc_q;
      f_inst_d  = f_inst_q;
      if (FLUSH) begin
         // Every unfilled entry becomes a response to discard; a response
         // landing in this very cycle is already consumed.
         drop_sum = SW'(drop_q) + SW'(unfilled);
         if (rsp && (drop_sum != '0)) drop_sum = drop_sum - SW'(1);
         drop_d    = PW'(drop_sum);
         f_valid_d = 1'b0;
      end else begin
         if (drop_rsp) drop_d = drop_q - PW'(1);
         if (!STALL) begin
            f_valid_d = head_filled;
            if (head_filled) begin
               f_pc_d   = head.pc;
               f_inst_d = head.inst;
            end
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         drop_q    <= '0;
         f_valid_q <= 1'b0;
         f_pc_q    <= RESET_VEC;
         f_inst_q  <= '0;
      end else begin
         drop_q    <= drop_d;
         f_valid_q <= f_valid_d;
         f_pc_q    <= f_pc_d;
         f_inst_q  <= f_inst_d;
      end
   end

   assign fetch_bus.INST_RDEN   = issue;
   assign fetch_bus.INST_RDADDR = fetch_bus.P_PC;
   assign fetch_bus.F_BUSY      = busy;
   assign fetch_bus.F_PC        = f_pc_q;
   assign fetch_bus.F_INST      = f_inst_q;
   assign fetch_bus.F_VALID     = f_valid_q;

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: directed scenarios followed by randomized traffic,
// checked cycle by cycle against a transaction-level model (epoch-tagged
// memory requests plus a queue of live fetch entries).
module tb_inst_fetch;
   import inst_fetch_pkg::*;

   localparam int unsigned DEPTH = 4;

   logic CLK = 1'b0;
   logic RST;
   logic STALL;
   logic FLUSH;

   inst_fetch_if bus ();

   inst_fetch #(
      .DEPTH (DEPTH)
   ) dut (
      .CLK       (CLK),
      .RST       (RST),
      .STALL     (STALL),
      .FLUSH     (FLUSH),
      .fetch_bus (bus)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] inst;
      bit          filled;
   } ent_t;

   typedef struct {
      logic [31:0] pc;
      int unsigned epoch;
      int unsigned due;
   } req_t;

   ent_t        mdl_buf [$];
   req_t        mem_q   [$];
   int unsigned epoch;
   int unsigned cyc;
   int unsigned lat;
   logic [31:0] pc_next;
   bit          exp_valid;
   logic [31:0] exp_pc;
   logic [31:0] exp_inst;
   int          n_checks;
   int          n_fail;
   int          n_issued;
   int          dut_deliv;
   logic [31:0] dut_last_pc;
   bit          busy_seen;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
   endfunction

   function automatic int stale_cnt();
      int n = 0;
      foreach (mem_q[i]) if (mem_q[i].epoch != epoch) n++;
      return n;
   endfunction

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s @cyc %0d: got %h expected %h", tag, cyc, obs, exp);
      end
   endtask

   // One clock cycle: drive, check combinational outputs, advance model, check registers
   task automatic step(input bit rst, input bit pv, input bit stall, input bit flush);
      bit   rsp;
      bit   exp_busy;
      bit   exp_issue;
      req_t m;
      rsp = !rst && (mem_q.size() > 0) && (mem_q[0].due <= cyc);
      RST              = rst;
      STALL            = stall;
      FLUSH            = flush;
      bus.P_VALID      = pv;
      bus.P_PC         = pc_next;
      bus.INST_RDVALID = rsp;
      bus.INST_RDDATA  = rsp ? mem_word(mem_q[0].pc) : $urandom();
      exp_busy  = (mdl_buf.size() + stale_cnt()) >= DEPTH;
      exp_issue = pv && !stall && !flush && !rst && !exp_busy;
      #1;
      check_eq("f_busy", 32'(bus.F_BUSY), 32'(exp_busy));
      check_eq("inst_rden", 32'(bus.INST_RDEN), 32'(exp_issue));
      if (exp_issue) check_eq("inst_rdaddr", bus.INST_RDADDR, pc_next);
      if (bus.F_BUSY) busy_seen = 1'b1;
      @(posedge CLK);
      if (rst) begin
         mdl_buf.delete();
         mem_q.delete();
         exp_valid = 1'b0;
         exp_pc    = '0;
         exp_inst  = '0;
         epoch++;
      end else begin
         if (flush) begin
            exp_valid = 1'b0;
         end else if (!stall) begin
            if (mdl_buf.size() > 0 && mdl_buf[0].filled) begin
               exp_valid = 1'b1;
               exp_pc    = mdl_buf[0].pc;
               exp_inst  = mdl_buf[0].inst;
               void'(mdl_buf.pop_front());
            end else begin
               exp_valid = 1'b0;
            end
         end
         if (rsp) begin
            m = mem_q.pop_front();
            if (!flush && m.epoch == epoch) begin
               for (int i = 0; i < mdl_buf.size(); i++) begin
                  if (!mdl_buf[i].filled) begin
                     mdl_buf[i].filled = 1'b1;
                     mdl_buf[i].inst   = mem_word(m.pc);
                     break;
                  end
               end
            end
         end
         if (flush) begin
            mdl_buf.delete();
            epoch++;
         end
         if (exp_issue) begin
            mdl_buf.push_back('{pc: pc_next, inst: 32'h0, filled: 1'b0});
            mem_q.push_back('{pc: pc_next, epoch: epoch, due: cyc + lat});
            pc_next = pc_next + 32'd4;
            n_issued++;
         end
      end
      cyc++;
      #1;
      check_eq("f_valid", 32'(bus.F_VALID), 32'(exp_valid));
      check_eq("f_pc", bus.F_PC, exp_pc);
      check_eq("f_inst", bus.F_INST, exp_inst);
      if (bus.F_VALID) begin
         dut_deliv++;
         dut_last_pc = bus.F_PC;
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      int d0;
      bit r, f, s, p;
      n_checks = 0; n_fail = 0; n_issued = 0; dut_deliv = 0;
      epoch = 0; cyc = 0; lat = 1; busy_seen = 1'b0;
      dut_last_pc = '0; exp_valid = 1'b0; exp_pc = '0; exp_inst = '0;
      pc_next = 32'h2000_0000;

      // Reset, then three sequential fetches with latency 1
      step(1'b1, 1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0, 1'b0);
      d0 = dut_deliv;
      for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 1'b0);
      idle(6);
      check_eq("seq3_count", 32'(dut_deliv - d0), 32'd3);
      check_eq("seq3_last_pc", dut_last_pc, 32'h2000_0008);

      // Latency 3, continuous fetch of 20 instructions, credit exhaustion
      lat = 3; d0 = dut_deliv; n_issued = 0; busy_seen = 1'b0;
      for (int i = 0; i < 200 && n_issued < 20; i++) step(1'b0, 1'b1, 1'b0, 1'b0);
      idle(10);
      check_eq("stream20_count", 32'(dut_deliv - d0), 32'd20);
      check_eq("stream20_busy_seen", 32'(busy_seen), 32'd1);
      check_eq("stream20_last_pc", dut_last_pc, 32'h2000_0058);

      // Three reads in flight at latency 4, flush, then redirect
      lat = 4; d0 = dut_deliv;
      for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b1, 1'b0, 1'b1);
      pc_next = 32'h2000_0100;
      step(1'b0, 1'b1, 1'b0, 1'b0);
      idle(12);
      check_eq("flush3_count", 32'(dut_deliv - d0), 32'd1);
      check_eq("flush3_pc", dut_last_pc, 32'h2000_0100);

      // Flush coincident with a response and two reads outstanding
      lat = 2; d0 = dut_deliv;
      for (int i = 0; i < 2; i++) step(1'b0, 1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b1, 1'b0, 1'b1);
      pc_next = 32'h2000_0200;
      for (int i = 0; i < 2; i++) step(1'b0, 1'b1, 1'b0, 1'b0);
      idle(8);
      check_eq("flush_rsp_count", 32'(dut_deliv - d0), 32'd2);
      check_eq("flush_rsp_pc", dut_last_pc, 32'h2000_0204);

      // Stall held five cycles while responses keep filling the buffer
      lat = 1; d0 = dut_deliv; pc_next = 32'h2000_0300;
      for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b1, 1'b0);
      idle(8);
      check_eq("stall_last_pc", dut_last_pc, 32'h2000_030C);

      // Reset with a full buffer of outstanding reads
      lat = 6; pc_next = 32'h2000_0400;
      for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b0);
      lat = 1; pc_next = 32'h2000_0000;
      for (int i = 0; i < 2; i++) step(1'b0, 1'b1, 1'b0, 1'b0);
      idle(6);
      check_eq("post_rst_pc", dut_last_pc, 32'h2000_0004);

      // Randomized traffic
      for (int i = 0; i < 3000; i++) begin
         if (i % 64 == 0) lat = $urandom_range(5, 1);
         r = ($urandom_range(199, 0) == 0);
         f = ($urandom_range(24, 0) == 0);
         s = ($urandom_range(7, 0) == 0);
         p = ($urandom_range(3, 0) != 0);
         step(r, p, s, f);
         if (r) pc_next = 32'h2000_0000;
         else if (f) pc_next = 32'h2000_0000 + ($urandom() & 32'h0000_0FFC);
      end
      idle(12);
      check_eq("drain_empty_busy", 32'(bus.F_BUSY), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
